// File: rtl/fft16_frame_streamer.sv
// ----------------------------------------------------------------------------
// fft16_frame_streamer
//
// Takes one 16-point FFT result frame at a time, presented in parallel, and
// streams it out as one complex bin per cycle over a valid/ready handshake.
// Two frame buffers (A/B) are used as a ping-pong pair. The FFT core can
// deliver frame k+1 while frame k is still draining.
//
// Configuration macro:
//   FFT16_STREAM_BITREV_EN  defined   -> bins emit in bit-reversed order
//                                         (0,8,4,12,...,15). m_index still
//                                         reports the true bin number.
//                           undefined -> bins emit in natural order 0..15.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous, active-high reset
//   in_valid  in   a frame is present on in_re/in_im
//   in_ready  out  at least one buffer is free (registered)
//   in_re     in   N signed real parts, bin i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_im     in   N signed imaginary parts, same packing
//   m_valid   out  output bin valid
//   m_ready   in   consumer accepts bin
//   m_re      out  real part of the current bin
//   m_im      out  imaginary part of the current bin
//   m_index   out  bin number of the current output
//   m_last    out  current bin is the 16th transfer of its frame
//   drop_cnt  out  saturating count of frames offered while in_ready = 0
// ----------------------------------------------------------------------------
module fft16_frame_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH*N-1:0] in_re,
  input  logic [DATA_WIDTH*N-1:0] in_im,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_re,
  output logic [DATA_WIDTH-1:0]   m_im,
  output logic [3:0]              m_index,
  output logic                    m_last,
  output logic [7:0]              drop_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] occ;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [3:0] seq;

  // Frame storage. Data only, so it is never reset.
  logic signed [DATA_WIDTH-1:0] buf_re [2][N];
  logic signed [DATA_WIDTH-1:0] buf_im [2][N];

  // The flat input buses, unpacked per bin.
  logic signed [DATA_WIDTH-1:0] in_re_a [N];
  logic signed [DATA_WIDTH-1:0] in_im_a [N];

  // Event decode and next-state values.
  logic       cap;
  logic       drop;
  logic       hs;
  logic       last_hs;
  logic [1:0] occ_nxt;
  logic [3:0] seq_nxt;
  logic       rd_ptr_nxt;
  logic       wr_ptr_nxt;
  logic [3:0] idx_p0;
  logic       bypass_p0;
  logic       vld_p0;
  logic       last_p0;
  logic signed [DATA_WIDTH-1:0] rd_re_p0;
  logic signed [DATA_WIDTH-1:0] rd_im_p0;

  // Maps a transfer sequence number to the bin it carries.
  function automatic logic [3:0] order(input logic [3:0] s);
`ifdef FFT16_STREAM_BITREV_EN
    return {s[0], s[1], s[2], s[3]};
`else
    return s;
`endif
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_re_a[i] = in_re[i*DATA_WIDTH +: DATA_WIDTH];
      in_im_a[i] = in_im[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign m_valid = (state == STREAM);
  assign cap     = in_valid & in_ready;
  assign drop    = in_valid & ~in_ready;
  assign hs      = m_valid & m_ready;
  assign last_hs = hs & m_last;

  always_comb begin
    occ_nxt = occ;
    case ({cap, last_hs})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  assign seq_nxt    = hs ? (seq + 4'd1) : seq;
  assign rd_ptr_nxt = rd_ptr ^ last_hs;
  assign wr_ptr_nxt = wr_ptr ^ cap;

  // Stage p0: select the bin that will be presented after this edge. If the
  // buffer being read next is the one being written at this same edge (an
  // empty streamer capturing, or a frame finishing while a new one arrives),
  // the buffer does not hold the data yet, so the bin is taken from the input.
  assign idx_p0    = order(seq_nxt);
  assign bypass_p0 = cap & (wr_ptr == rd_ptr_nxt);
  assign vld_p0    = (occ_nxt != 2'd0);
  assign last_p0   = vld_p0 & (seq_nxt == 4'd15);
  assign rd_re_p0  = bypass_p0 ? in_re_a[idx_p0] : buf_re[rd_ptr_nxt][idx_p0];
  assign rd_im_p0  = bypass_p0 ? in_im_a[idx_p0] : buf_im[rd_ptr_nxt][idx_p0];

  // Stage p1: registered control and output bin. During a stall, seq and
  // rd_ptr do not move, and the read buffer is not the write target. So the
  // same bin is reselected and the outputs hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      seq      <= 4'd0;
      in_ready <= 1'b1;
      drop_cnt <= 8'd0;
      m_re     <= '0;
      m_im     <= '0;
      m_index  <= 4'd0;
      m_last   <= 1'b0;
    end else begin
      state    <= vld_p0 ? STREAM : IDLE;
      occ      <= occ_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      seq      <= seq_nxt;
      in_ready <= (occ_nxt != 2'd2);
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      m_re    <= vld_p0 ? rd_re_p0 : '0;
      m_im    <= vld_p0 ? rd_im_p0 : '0;
      m_index <= vld_p0 ? idx_p0 : 4'd0;
      m_last  <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 0; i < N; i++) begin
        buf_re[wr_ptr][i] <= in_re_a[i];
        buf_im[wr_ptr][i] <= in_im_a[i];
      end
    end
  end

endmodule

// File: tb/tb_fft16_frame_streamer.sv
module tb_fft16_frame_streamer;
  localparam int DW = 16;
  localparam int N  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW*N-1:0] in_re;
  logic [DW*N-1:0] in_im;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_re;
  logic [DW-1:0]   m_im;
  logic [3:0]      m_index;
  logic            m_last;
  logic [7:0]      drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fft16_frame_streamer #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_re     (m_re),
    .m_im     (m_im),
    .m_index  (m_index),
    .m_last   (m_last),
    .drop_cnt (drop_cnt)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
  } vec_t;

  vec_t       tbl [16];
  logic [3:0] ord [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_const(input logic [15:0] v);
    for (int i = 0; i < N; i++) begin
      in_re[i*DW +: DW] = v;
      in_im[i*DW +: DW] = v;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lfsr;
    int          xfer;

`ifdef FFT16_STREAM_BITREV_EN
    ord = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
            4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
`else
    for (int i = 0; i < 16; i++) ord[i] = 4'(i);
`endif
    for (int k = 0; k < 16; k++) begin
      tbl[k].idx  = ord[k];
      tbl[k].re   = 16'(16 * int'(ord[k]));
      tbl[k].im   = 16'(-int'(ord[k]));
      tbl[k].last = (k == 15);
    end

    // Reset values
    rst = 1'b1; in_valid = 1'b0; m_ready = 1'b0; in_re = '0; in_im = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_m_valid",  m_valid,  1'b0);
    check("rst_m_re",     m_re,     16'h0);
    check("rst_m_im",     m_im,     16'h0);
    check("rst_m_index",  m_index,  4'd0);
    check("rst_m_last",   m_last,   1'b0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    rst = 1'b0;
    tick();
    check("post_rst_m_valid", m_valid, 1'b0);

    // Single frame, re = 16*i, im = -i
    for (int i = 0; i < N; i++) begin
      in_re[i*DW +: DW] = 16'(16 * i);
      in_im[i*DW +: DW] = 16'(-i);
    end
    in_valid = 1'b1; m_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("sf_valid", m_valid, 1'b1);
      check("sf_index", m_index, tbl[k].idx);
      check("sf_re",    m_re,    tbl[k].re);
      check("sf_im",    m_im,    tbl[k].im);
      check("sf_last",  m_last,  tbl[k].last);
      tick();
    end
    check("sf_valid_after", m_valid,  1'b0);
    check("sf_in_ready",    in_ready, 1'b1);

    // Back-pressure with pseudo-random m_ready (LFSR seeded with 1)
    set_const(16'h7FFF);
    in_valid = 1'b1; m_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lfsr = 16'd1;
    xfer = 0;
    for (int cyc = 0; cyc < 400 && xfer < 16; cyc++) begin
      check("bp_valid", m_valid, 1'b1);
      check("bp_index", m_index, ord[xfer]);
      check("bp_re",    m_re,    16'h7FFF);
      check("bp_im",    m_im,    16'h7FFF);
      check("bp_last",  m_last,  (xfer == 15));
      lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      m_ready = lfsr[0];
      if (m_ready) xfer++;
      tick();
    end
    check("bp_count",       16'(xfer), 16'd16);
    check("bp_valid_after", m_valid,   1'b0);

    // Ping-pong: F1 = 1, F2 = 2 in consecutive cycles
    m_ready = 1'b1;
    set_const(16'd1);
    in_valid = 1'b1;
    tick();
    set_const(16'd2);
    for (int c = 0; c < 32; c++) begin
      check("pp_valid",    m_valid,  1'b1);
      check("pp_re",       m_re,     (c < 16) ? 16'd1 : 16'd2);
      check("pp_im",       m_im,     (c < 16) ? 16'd1 : 16'd2);
      check("pp_index",    m_index,  ord[c % 16]);
      check("pp_last",     m_last,   ((c % 16) == 15));
      check("pp_in_ready", in_ready, (c == 0 || c >= 16));
      tick();
      if (c == 0) in_valid = 1'b0;
    end
    check("pp_valid_after", m_valid,  1'b0);
    check("pp_ready_after", in_ready, 1'b1);

    // Overflow, drop saturation and mid-stream reset
    m_ready = 1'b0;
    set_const(16'd5);
    in_valid = 1'b1;
    tick();
    check("ovf_ready1", in_ready, 1'b1);
    check("ovf_valid1", m_valid,  1'b1);
    tick();
    check("ovf_ready2", in_ready, 1'b0);
    check("ovf_drop0",  drop_cnt, 8'd0);
    tick();
    check("ovf_drop1",  drop_cnt, 8'd1);
    repeat (260) tick();
    check("ovf_drop_sat", drop_cnt, 8'd255);
    in_valid = 1'b0;
    tick();
    check("ovf_stall_index", m_index,  ord[0]);
    check("ovf_stall_re",    m_re,     16'd5);
    check("ovf_stall_ready", in_ready, 1'b0);
    m_ready = 1'b1;
    repeat (5) tick();
    check("mid_index", m_index, ord[5]);
    check("mid_valid", m_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_valid",    m_valid,  1'b0);
    check("arst_drop_cnt", drop_cnt, 8'd0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_index",    m_index,  4'd0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_no_resume", m_valid, 1'b0);
    set_const(16'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("arst_new_index", m_index, ord[0]);
    check("arst_new_re",    m_re,    16'd3);
    repeat (16) tick();
    check("arst_new_drain", m_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
